// File: rtl/gb_joypad_pkg.sv
// Shared constants and types for the Game Boy joypad (P1/FF00) block.
package gb_joypad_pkg;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_A      = 4;
  localparam int JOY_B      = 5;
  localparam int JOY_SELECT = 6;
  localparam int JOY_START  = 7;

  // p1_sel = {P15, P14}; a 0 selects the corresponding key group
  localparam logic [1:0] P1_SEL_BOTH = 2'b00;
  localparam logic [1:0] P1_SEL_BTN  = 2'b01;
  localparam logic [1:0] P1_SEL_DIR  = 2'b10;
  localparam logic [1:0] P1_SEL_NONE = 2'b11;

  typedef logic [3:0] nibble_t;

endpackage

// File: rtl/gb_joypad_if.sv
// CPU-side P1 register access and interrupt request.
interface gb_joypad_if;
  logic       cpu_sel;
  logic       cpu_wr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       irq;

  modport master (output cpu_sel, cpu_wr, cpu_din, input cpu_dout, irq);
  modport slave  (input cpu_sel, cpu_wr, cpu_din, output cpu_dout, irq);
endinterface

// File: rtl/gb_joypad_debounce_bit.sv
// One key: 2-flop synchronizer, saturating hold counter and accepted level.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // this edge is the DEBOUNCE_CYCLES-th consecutive differing sample
        stable <= sync2;
        cnt    <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gb_joypad.sv
// Game Boy P1/FF00 joypad register: debounced keys, select lines, falling-edge irq.
module gb_joypad
  import gb_joypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit BLOCK_OPPOSING  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  joystick,
  gb_joypad_if.slave  bus
);

  logic [7:0] state;
  logic [7:0] masked;
  logic [1:0] p1_sel;
  nibble_t    nibble;
  nibble_t    dir_keys;
  nibble_t    btn_keys;
  nibble_t    line_now;
  nibble_t    line_prev;
  logic       irq_q;
  logic       unused_din;

  for (genvar i = 0; i < 8; i++) begin : g_db
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (joystick[i]),
      .stable  (state[i])
    );
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    masked = state;
    if (BLOCK_OPPOSING) begin
      if (state[JOY_LEFT] && state[JOY_RIGHT]) begin
        masked[JOY_LEFT]  = 1'b0;
        masked[JOY_RIGHT] = 1'b0;
      end
      if (state[JOY_UP] && state[JOY_DOWN]) begin
        masked[JOY_UP]   = 1'b0;
        masked[JOY_DOWN] = 1'b0;
      end
    end
  end

  assign dir_keys = {masked[JOY_DOWN], masked[JOY_UP], masked[JOY_LEFT], masked[JOY_RIGHT]};
  assign btn_keys = {masked[JOY_START], masked[JOY_SELECT], masked[JOY_B], masked[JOY_A]};

  always_comb begin
    nibble = '0;
    case (p1_sel)
      P1_SEL_DIR:  nibble = dir_keys;
      P1_SEL_BTN:  nibble = btn_keys;
      P1_SEL_BOTH: nibble = dir_keys | btn_keys;
      P1_SEL_NONE: nibble = '0;
      default:     nibble = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_sel <= P1_SEL_NONE;
    end else if (bus.cpu_sel && bus.cpu_wr) begin
      p1_sel <= bus.cpu_din[5:4];
    end
  end

  assign unused_din = ^{bus.cpu_din[7:6], bus.cpu_din[3:0]};

  assign line_now     = ~nibble;
  assign bus.cpu_dout = {2'b11, p1_sel, line_now};
  assign bus.irq      = irq_q;

  // irq fires on any 1->0 of the visible low nibble, whatever caused it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_prev <= 4'hF;
      irq_q     <= 1'b0;
    end else begin
      line_prev <= line_now;
      irq_q     <= |(line_prev & ~line_now);
    end
  end

endmodule
